// File: rtl/reg_readout_seq_pkg.sv
// rtl/reg_readout_seq_pkg.sv - shared state encodings and default widths for the readout sequencer
package reg_readout_seq_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/readout_addr_ctr.sv
// rtl/readout_addr_ctr.sv - loadable wrapping address counter with remaining-word down-counter
module readout_addr_ctr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W:0]   load_count,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W:0] remaining;

  // addr wraps naturally at 2**ADDR_W; bursts longer than the bank repeat addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_count;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/reg_readout_seq.sv
// rtl/reg_readout_seq.sv - walks a register address range and streams each word over valid/ready
module reg_readout_seq
  import reg_readout_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] o_data_nxt;
  logic              err_nxt;
  logic              load, step, last;

  readout_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_addr  (first_addr),
    .load_count (count),
    .step       (step),
    .addr       (rd_addr),
    .last       (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      o_data  <= '0;
      err     <= 1'b0;
      rd_en   <= 1'b0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_data  <= o_data_nxt;
      err     <= err_nxt;
      rd_en   <= (state_nxt == ST_FETCH);
      o_valid <= (state_nxt == ST_SEND);
      busy    <= (state_nxt == ST_FETCH) || (state_nxt == ST_SEND);
      done    <= (state_nxt == ST_DONE);
    end
  end

  always_comb begin
    state_nxt  = state;
    o_data_nxt = o_data;
    err_nxt    = err;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start) begin
          if (count == '0) begin
            err_nxt = 1'b1;
          end else begin
            load      = 1'b1;
            err_nxt   = 1'b0;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        o_data_nxt = rd_data;
        state_nxt  = ST_SEND;
        if (start) err_nxt = 1'b1;
      end
      ST_SEND: begin
        if (start) err_nxt = 1'b1;
        // last word leaves the address where it is; otherwise advance for the next fetch
        if (o_valid && o_ready) begin
          if (last) begin
            state_nxt = ST_DONE;
          end else begin
            step      = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_readout_seq.sv
// tb/tb_reg_readout_seq.sv - directed self-checking bench for reg_readout_seq
module tb_reg_readout_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  first_addr = '0;
  logic [4:0]  count = '0;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [11:0] rd_data;
  logic [11:0] o_data;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  logic [11:0] bank [16];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rd_data = bank[rd_addr];

  reg_readout_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .count      (count),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check_all_zero(input string name);
    total++;
    if ({rd_addr, rd_en, o_data, o_valid, busy, done, err} !== 22'd0) begin
      bad++;
      $display("FAIL %s: outs addr=%h en=%b data=%h v=%b busy=%b done=%b err=%b, want all 0",
               name, rd_addr, rd_en, o_data, o_valid, busy, done, err);
    end
  endtask

  // Starts a burst at the current negedge with o_ready high and follows it to DONE.
  task automatic run_burst(input logic [3:0] first, input logic [4:0] cnt, input string name);
    logic [3:0] addr;
    addr = first;
    start = 1'b1; first_addr = first; count = cnt; o_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(cnt); i++) begin
      total++;
      if ({rd_en, rd_addr, o_valid, busy} !== {1'b1, addr, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL %s fetch%0d: en=%b addr=%h v=%b busy=%b, want en=1 addr=%h v=0 busy=1",
                 name, i, rd_en, rd_addr, o_valid, busy, addr);
      end
      if (i == 0) begin
        total++;
        if (err !== 1'b0) begin
          bad++;
          $display("FAIL %s err_clear: err=%b want 0", name, err);
        end
      end
      @(negedge clk);
      total++;
      if ({o_valid, o_data, rd_en} !== {1'b1, 12'h100 + 12'(addr), 1'b0}) begin
        bad++;
        $display("FAIL %s send%0d: v=%b data=%h en=%b, want v=1 data=%h en=0",
                 name, i, o_valid, o_data, rd_en, 12'h100 + 12'(addr));
      end
      @(negedge clk);
      addr = addr + 4'd1;
    end
    total++;
    if ({done, busy, o_valid, rd_en} !== 4'b1000) begin
      bad++;
      $display("FAIL %s done: done=%b busy=%b v=%b en=%b, want 1 0 0 0",
               name, done, busy, o_valid, rd_en);
    end
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    total++;
    if ({done, busy, o_valid, rd_en} !== 4'b0000) begin
      bad++;
      $display("FAIL %s idle: done=%b busy=%b v=%b en=%b, want 0 0 0 0",
               name, done, busy, o_valid, rd_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
  endtask

  task automatic test_basic();
    run_burst(4'h0, 5'd3, "basic");
    expect_idle("basic");
  endtask

  task automatic test_wrap();
    run_burst(4'hE, 5'd4, "wrap");
    expect_idle("wrap");
  endtask

  task automatic test_full_range();
    run_burst(4'h8, 5'd16, "full16");
    expect_idle("full16");
  endtask

  task automatic test_stall();
    start = 1'b1; first_addr = 4'h5; count = 5'd2; o_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({rd_en, rd_addr} !== {1'b1, 4'h5}) begin
      bad++;
      $display("FAIL stall fetch: en=%b addr=%h want 1 5", rd_en, rd_addr);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_data, rd_en, rd_addr} !== {1'b1, 12'h105, 1'b0, 4'h5}) begin
        bad++;
        $display("FAIL stall hold%0d: v=%b data=%h en=%b addr=%h want 1 105 0 5",
                 k, o_valid, o_data, rd_en, rd_addr);
      end
    end
    o_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({rd_en, rd_addr, o_valid} !== {1'b1, 4'h6, 1'b0}) begin
      bad++;
      $display("FAIL stall refetch: en=%b addr=%h v=%b want 1 6 0", rd_en, rd_addr, o_valid);
    end
    @(negedge clk);
    total++;
    if ({o_valid, o_data} !== {1'b1, 12'h106}) begin
      bad++;
      $display("FAIL stall word2: v=%b data=%h want 1 106", o_valid, o_data);
    end
    @(negedge clk);
    total++;
    if ({done, o_valid} !== 2'b10) begin
      bad++;
      $display("FAIL stall done: done=%b v=%b want 1 0", done, o_valid);
    end
    expect_idle("stall");
  endtask

  task automatic test_zero_count();
    start = 1'b1; first_addr = 4'h2; count = 5'd0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({err, busy, rd_en, o_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL zero_count: err=%b busy=%b en=%b v=%b want 1 0 0 0", err, busy, rd_en, o_valid);
    end
    @(negedge clk);
    total++;
    if ({err, busy} !== 2'b10) begin
      bad++;
      $display("FAIL zero_count sticky: err=%b busy=%b want 1 0", err, busy);
    end
    run_burst(4'h9, 5'd1, "after_zero");
    expect_idle("after_zero");
  endtask

  task automatic test_start_while_busy();
    start = 1'b1; first_addr = 4'h3; count = 5'd2; o_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({o_valid, o_data, err} !== {1'b1, 12'h103, 1'b0}) begin
      bad++;
      $display("FAIL busy_start word1: v=%b data=%h err=%b want 1 103 0", o_valid, o_data, err);
    end
    start = 1'b1; first_addr = 4'h0; count = 5'd5;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({err, rd_en, rd_addr} !== {1'b1, 1'b1, 4'h4}) begin
      bad++;
      $display("FAIL busy_start err: err=%b en=%b addr=%h want 1 1 4", err, rd_en, rd_addr);
    end
    @(negedge clk);
    total++;
    if ({o_valid, o_data} !== {1'b1, 12'h104}) begin
      bad++;
      $display("FAIL busy_start word2: v=%b data=%h want 1 104", o_valid, o_data);
    end
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b11) begin
      bad++;
      $display("FAIL busy_start done: done=%b err=%b want 1 1", done, err);
    end
    @(negedge clk);
    total++;
    if ({busy, err} !== 2'b01) begin
      bad++;
      $display("FAIL busy_start sticky: busy=%b err=%b want 0 1", busy, err);
    end
  endtask

  task automatic test_back_to_back();
    run_burst(4'h1, 5'd1, "b2b_a");
    run_burst(4'hA, 5'd2, "b2b_b");
    expect_idle("b2b");
  endtask

  task automatic test_mid_reset();
    start = 1'b1; first_addr = 4'h2; count = 5'd3; o_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_valid, o_data} !== {1'b1, 12'h103}) begin
      bad++;
      $display("FAIL midrst word2: v=%b data=%h want 1 103", o_valid, o_data);
    end
    rst = 1'b0;
    #1;
    check_all_zero("midrst_async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst_idle");
    run_burst(4'h7, 5'd2, "after_rst");
    expect_idle("after_rst");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = 12'h100 + 12'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_count();
    test_start_while_busy();
    test_back_to_back();
    test_full_range();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
